fetch_decode_queue: RTL and testbench

//  Parametrised successor to the single-entry fetch/decode pipeline register.

---
 rtl/fetch_decode_queue_pkg.sv | 24 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/fetch_decode_queue.sv | 128 ++++++++++++
 tb/tb_fetch_decode_queue.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_queue_pkg.sv
// +--------------------------------------------------------------------+
// | fetch_decode_queue_pkg: shared constants and decode-action type    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

package fetch_decode_queue_pkg;
   localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
   localparam logic        STOP         = 1'b1;
   localparam logic        NO_STOP      = 1'b0;
   localparam logic        RST_ENABLE   = 1'b0;
   localparam int          ID_STALL_BIT = 2;
   localparam int          STALL_BUS_W  = 6;

   typedef enum logic [2:0] {
      ACT_BUBBLE = 3'd0,
      ACT_FLUSH  = 3'd1,
      ACT_HOLD   = 3'd2,
      ACT_POP    = 3'd3,
      ACT_BYPASS = 3'd4
   } dec_act_e;
endpackage

`default_nettype wire

// File: rtl/sync_fifo.sv
// +--------------------------------------------------------------------+
// | sync_fifo: power-of-two synchronous FIFO with clear, show-ahead    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module sync_fifo
   import fetch_decode_queue_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clear,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic [$clog2(DEPTH):0]     count,
   output logic                       full,
   output logic                       empty
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= din;
      end
   end

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + (PTR_W+1)'(1);
            2'b01:   count <= count - (PTR_W+1)'(1);
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (PTR_W+1)'(DEPTH));
   assign empty = (count == '0);
endmodule

`default_nettype wire

// File: rtl/fetch_decode_queue.sv
// +--------------------------------------------------------------------+
// | fetch_decode_queue: tracks in-flight fetches, buffers responses    |
// | and drives the decode-stage register.  Rev 1.0                     |
// +--------------------------------------------------------------------+
`default_nettype none

module fetch_decode_queue
   import fetch_decode_queue_pkg::*;
#(
   parameter int ADDR_W  = 32,
   parameter int INST_W  = 32,
   parameter int MEM_LAT = 1,
   parameter int DEPTH   = 4,
   parameter int STALL_W = STALL_BUS_W,
   parameter int ID_BIT  = ID_STALL_BIT
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  if_pc,
   input  logic               if_req,
   input  logic [INST_W-1:0]  if_inst,
   input  logic               flush,
   input  logic [STALL_W-1:0] stall,
   output logic               fetch_ready,
   output logic [ADDR_W-1:0]  id_pc,
   output logic [INST_W-1:0]  id_inst,
   output logic               id_valid
);
   localparam int CNT_W   = $clog2(DEPTH) + 1;
   localparam int IF_W    = $clog2(MEM_LAT + 1);
   localparam int SUM_W   = $clog2(DEPTH + MEM_LAT + 1);
   localparam int ENTRY_W = ADDR_W + INST_W;

   logic [MEM_LAT-1:0] dl_v;
   logic [ADDR_W-1:0]  dl_pc [MEM_LAT];
   logic               rsp_v;
   logic [ADDR_W-1:0]  rsp_pc;
   logic [IF_W-1:0]    inflight;

   logic [CNT_W-1:0]   fifo_count;
   logic               fifo_full;
   logic               fifo_empty;
   logic               fifo_push;
   logic               fifo_pop;
   logic [ENTRY_W-1:0] fifo_dout;
   dec_act_e           act;
   logic               unused_ok;

   assign rsp_v  = dl_v[MEM_LAT-1];
   assign rsp_pc = dl_pc[MEM_LAT-1];

   always_comb begin
      inflight = '0;
      for (int i = 0; i < MEM_LAT; i++) begin
         inflight = inflight + IF_W'(dl_v[i]);
      end
   end

   // Credit check uses registered state only, so no stall/if_req feedthrough.
   assign fetch_ready = (SUM_W'(fifo_count) + SUM_W'(inflight)) < SUM_W'(DEPTH);

   always_comb begin
      act = ACT_BUBBLE;
      if (flush)                        act = ACT_FLUSH;
      else if (stall[ID_BIT] == STOP)   act = ACT_HOLD;
      else if (!fifo_empty)             act = ACT_POP;
      else if (rsp_v)                   act = ACT_BYPASS;
   end

   assign fifo_push = rsp_v && (act == ACT_HOLD || act == ACT_POP);
   assign fifo_pop  = (act == ACT_POP);

   sync_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clear (flush),
      .push  (fifo_push),
      .pop   (fifo_pop),
      .din   ({rsp_pc, if_inst}),
      .dout  (fifo_dout),
      .count (fifo_count),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   always_ff @(posedge clk) begin
      if (rst == RST_ENABLE) begin
         dl_v     <= '0;
         for (int i = 0; i < MEM_LAT; i++) dl_pc[i] <= '0;
         id_valid <= 1'b0;
         id_pc    <= '0;
         id_inst  <= '0;
      end else begin
         dl_v[0]  <= if_req & fetch_ready & ~flush;
         dl_pc[0] <= if_pc;
         for (int i = 1; i < MEM_LAT; i++) begin
            dl_v[i]  <= dl_v[i-1] & ~flush;
            dl_pc[i] <= dl_pc[i-1];
         end
         case (act)
            ACT_POP: begin
               id_valid         <= 1'b1;
               {id_pc, id_inst} <= fifo_dout;
            end
            ACT_BYPASS: begin
               id_valid <= 1'b1;
               id_pc    <= rsp_pc;
               id_inst  <= if_inst;
            end
            ACT_HOLD: begin
               id_valid <= id_valid;
            end
            default: begin
               id_valid <= 1'b0;
               id_pc    <= '0;
               id_inst  <= INST_W'(ZERO_WORD);
            end
         endcase
      end
   end

   assign unused_ok = ^{stall, fifo_full};
endmodule

`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
// +--------------------------------------------------------------------+
// | tb_fetch_decode_queue: directed vector bench for fetch_decode_queue|
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_fetch_decode_queue;
   import fetch_decode_queue_pkg::*;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [31:0] if_pc, if_inst, id_pc, id_inst;
   logic        if_req, flush, fetch_ready, id_valid;
   logic [5:0]  stall;

   logic [31:0] if_pc3, if_inst3, id_pc3, id_inst3;
   logic        if_req3, flush3, fetch_ready3, id_valid3;
   logic [5:0]  stall3;

   int errors = 0;
   int checks = 0;

   function automatic logic [31:0] rom(input logic [31:0] pc);
      return pc ^ 32'hC0DE_0000;
   endfunction

   // Instruction ROM models: data returns MEM_LAT cycles after the address.
   logic [31:0] rom1_pc;
   logic [31:0] rom3_pc [3];
   always @(posedge clk) begin
      rom1_pc    <= if_pc;
      rom3_pc[0] <= if_pc3;
      rom3_pc[1] <= rom3_pc[0];
      rom3_pc[2] <= rom3_pc[1];
   end
   assign if_inst  = rom(rom1_pc);
   assign if_inst3 = rom(rom3_pc[2]);

   fetch_decode_queue #(.ADDR_W(32), .INST_W(32), .MEM_LAT(1), .DEPTH(4),
                        .STALL_W(6), .ID_BIT(2)) dut (
      .clk(clk), .rst(rst), .if_pc(if_pc), .if_req(if_req), .if_inst(if_inst),
      .flush(flush), .stall(stall), .fetch_ready(fetch_ready),
      .id_pc(id_pc), .id_inst(id_inst), .id_valid(id_valid));

   fetch_decode_queue #(.ADDR_W(32), .INST_W(32), .MEM_LAT(3), .DEPTH(4),
                        .STALL_W(6), .ID_BIT(2)) dut3 (
      .clk(clk), .rst(rst), .if_pc(if_pc3), .if_req(if_req3), .if_inst(if_inst3),
      .flush(flush3), .stall(stall3), .fetch_ready(fetch_ready3),
      .id_pc(id_pc3), .id_inst(id_inst3), .id_valid(id_valid3));

   always @(negedge clk) begin
      if (rst === 1'b1 && dut.fifo_push === 1'b1 && dut.fifo_full === 1'b1) begin
         errors++;
         $display("FAIL fifo_overflow at %0t: push while full", $time);
      end
   end

   // ctl = {rst, req, stall_id, flush}; ex = {exp_valid, exp_ready}
   typedef struct {
      logic [3:0]  ctl;
      logic [31:0] pc;
      logic [1:0]  ex;
      logic [31:0] epc;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic [3:0] ctl, input logic [31:0] pc,
                               input logic [1:0] ex, input logic [31:0] epc);
      vec_t v;
      v.ctl = ctl; v.pc = pc; v.ex = ex; v.epc = epc;
      return v;
   endfunction

   task automatic chk(input string nm, input int row, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row=%0d got=%h expected=%h", nm, row, act, exp);
      end
   endtask

   initial begin
      // reset
      vecs.push_back(mk(4'b0000, 32'h00, 2'b01, 32'h00));
      vecs.push_back(mk(4'b0000, 32'h00, 2'b01, 32'h00));
      // streaming, no stall
      vecs.push_back(mk(4'b1100, 32'h00, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h04, 2'b11, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h08, 2'b11, 32'h04));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h08));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      // three-cycle decode stall mid-stream
      vecs.push_back(mk(4'b1100, 32'h00, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h04, 2'b11, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h08, 2'b11, 32'h04));
      vecs.push_back(mk(4'b1110, 32'h0C, 2'b11, 32'h04));
      vecs.push_back(mk(4'b1010, 32'h00, 2'b11, 32'h04));
      vecs.push_back(mk(4'b1010, 32'h00, 2'b11, 32'h04));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h08));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h0C));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      // continuous stall until credits run out
      vecs.push_back(mk(4'b1110, 32'h20, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h24, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h28, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h2C, 2'b00, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h30, 2'b00, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h34, 2'b00, 32'h00));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h20));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h24));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h28));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h2C));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      // flush with 3 queued and 1 in flight
      vecs.push_back(mk(4'b1110, 32'h50, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h54, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h58, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1110, 32'h5C, 2'b00, 32'h00));
      vecs.push_back(mk(4'b1101, 32'h60, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h40, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b11, 32'h40));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      // flush and stall together
      vecs.push_back(mk(4'b1100, 32'h70, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h74, 2'b11, 32'h70));
      vecs.push_back(mk(4'b1110, 32'h78, 2'b11, 32'h70));
      vecs.push_back(mk(4'b1011, 32'h00, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      // reset mid-stream with entries queued
      vecs.push_back(mk(4'b1100, 32'h80, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1100, 32'h84, 2'b11, 32'h80));
      vecs.push_back(mk(4'b1110, 32'h88, 2'b11, 32'h80));
      vecs.push_back(mk(4'b1010, 32'h00, 2'b11, 32'h80));
      vecs.push_back(mk(4'b0110, 32'h8C, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));
      vecs.push_back(mk(4'b1000, 32'h00, 2'b01, 32'h00));

      if_req3 = 1'b0; if_pc3 = '0; flush3 = 1'b0; stall3 = '0;

      for (int i = 0; i < vecs.size(); i++) begin
         rst    = vecs[i].ctl[3];
         if_req = vecs[i].ctl[2];
         stall  = {3'b101, (vecs[i].ctl[1] ? STOP : NO_STOP), 2'b10};
         flush  = vecs[i].ctl[0];
         if_pc  = vecs[i].pc;
         @(posedge clk); #1;
         chk("id_valid", i, {31'b0, id_valid}, {31'b0, vecs[i].ex[1]});
         chk("id_pc", i, id_pc, vecs[i].epc);
         chk("id_inst", i, id_inst, vecs[i].ex[1] ? rom(vecs[i].epc) : 32'h0);
         chk("fetch_ready", i, {31'b0, fetch_ready}, {31'b0, vecs[i].ex[0]});
      end

      // Three-cycle memory: first fetch reaches decode four edges later.
      if_req = 1'b0; flush = 1'b0; stall = '0; rst = 1'b1;
      for (int c = 0; c < 8; c++) begin
         logic        ev;
         logic [31:0] ep;
         if_req3 = (c < 3);
         if_pc3  = 32'(c * 4);
         @(posedge clk); #1;
         ev = (c >= 3 && c <= 5);
         ep = ev ? 32'((c - 3) * 4) : 32'h0;
         chk("lat3_valid", c, {31'b0, id_valid3}, {31'b0, ev});
         chk("lat3_pc", c, id_pc3, ep);
         chk("lat3_inst", c, id_inst3, ev ? rom(ep) : 32'h0);
         chk("lat3_ready", c, {31'b0, fetch_ready3}, 32'h1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

`default_nettype wire
